// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: run-control FSM, redirect path and load counter.
// Optional single-step mode is compiled in when PC_STEP_EN is defined.
module pc_unit #(
    parameter int                 PC_SIZE      = 32,
    parameter logic [PC_SIZE-1:0] RESET_VECTOR = '0,
    parameter int                 COUNT_BITS   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_halt,
    input  logic                  i_step,
    input  logic                  i_enable,
    input  logic                  i_not_load,
    input  logic                  i_redirect,
    input  logic [PC_SIZE-1:0]    i_redirect_pc,
    input  logic [PC_SIZE-1:0]    i_next_pc,
    output logic [PC_SIZE-1:0]    o_pc,
    output logic                  o_running,
    output logic                  o_halted,
    output logic                  o_step_done,
    output logic [COUNT_BITS-1:0] o_load_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
`ifdef PC_STEP_EN
        ,
        ST_STEP   = 2'd3
`endif
    } state_t;

    state_t state;
    state_t state_next;
    logic   active;
    logic   pc_load;

`ifdef PC_STEP_EN
    assign active = (state == ST_RUN) || (state == ST_STEP);
`else
    assign active = (state == ST_RUN);
`endif

    // A halt cycle never loads; a redirect wins over a hazard stall.
    assign pc_load = active && i_enable && !i_halt && (i_redirect || !i_not_load);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_enable) begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (i_start) begin
                        state_next = ST_RUN;
                    end
`ifdef PC_STEP_EN
                    else if (i_step && !i_halt) begin
                        state_next = ST_STEP;
                    end
`endif
                end
                ST_RUN: begin
                    if (i_halt) begin
                        state_next = ST_HALTED;
                    end
                end
`ifdef PC_STEP_EN
                ST_STEP: begin
                    if (i_halt || pc_load) begin
                        state_next = ST_HALTED;
                    end
                end
`endif
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_running = active;
        o_halted  = (state == ST_HALTED);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pc         <= RESET_VECTOR;
            o_load_count <= '0;
        end else if (pc_load) begin
            o_pc         <= i_redirect ? i_redirect_pc : i_next_pc;
            o_load_count <= o_load_count + {{(COUNT_BITS-1){1'b0}}, 1'b1};
        end
    end

`ifdef PC_STEP_EN
    logic step_done_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            step_done_q <= 1'b0;
        end else begin
            step_done_q <= pc_load && (state == ST_STEP);
        end
    end

    assign o_step_done = step_done_q;
`else
    logic unused_step;
    assign unused_step = i_step;
    assign o_step_done = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: table-driven vectors through an expected-value queue,
// plus hand-written async-reset and counter-wrap sequences.
module tb_pc_unit;

    localparam int PC_SIZE    = 32;
    localparam int COUNT_BITS = 16;
    localparam logic [31:0] RV = 32'h100;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_halt = 1'b0;
    logic        i_step = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_not_load = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic [31:0] i_next_pc = '0;
    logic [31:0] o_pc;
    logic        o_running;
    logic        o_halted;
    logic        o_step_done;
    logic [15:0] o_load_count;

    pc_unit #(
        .PC_SIZE      (PC_SIZE),
        .RESET_VECTOR (RV),
        .COUNT_BITS   (COUNT_BITS)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_halt        (i_halt),
        .i_step        (i_step),
        .i_enable      (i_enable),
        .i_not_load    (i_not_load),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_next_pc     (i_next_pc),
        .o_pc          (o_pc),
        .o_running     (o_running),
        .o_halted      (o_halted),
        .o_step_done   (o_step_done),
        .o_load_count  (o_load_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       tag;
        logic        start, halt, step, en, nl, rd;
        logic [31:0] rpc, npc;
        logic [31:0] e_pc;
        logic [15:0] e_cnt;
        logic        e_run, e_halt, e_done;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [15:0] cnt;
        logic        run, halt, done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errCount = 0;
    int   checkCount = 0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input string tag, input logic start, input logic halt, input logic step,
                          input logic en, input logic nl, input logic rd,
                          input logic [31:0] rpc, input logic [31:0] npc,
                          input logic [31:0] e_pc, input logic [15:0] e_cnt,
                          input logic e_run, input logic e_halt, input logic e_done);
        vec_t v;
        v.tag = tag; v.start = start; v.halt = halt; v.step = step; v.en = en;
        v.nl = nl; v.rd = rd; v.rpc = rpc; v.npc = npc; v.e_pc = e_pc; v.e_cnt = e_cnt;
        v.e_run = e_run; v.e_halt = e_halt; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        checkValue({e.tag, ".pc"}, o_pc, e.pc);
        checkValue({e.tag, ".cnt"}, {16'h0, o_load_count}, {16'h0, e.cnt});
        checkValue({e.tag, ".flags"}, {29'h0, o_running, o_halted, o_step_done},
                   {29'h0, e.run, e.halt, e.done});
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge i_clk);
        i_start = v.start; i_halt = v.halt; i_step = v.step; i_enable = v.en;
        i_not_load = v.nl; i_redirect = v.rd; i_redirect_pc = v.rpc; i_next_pc = v.npc;
        e.tag = v.tag; e.pc = v.e_pc; e.cnt = v.e_cnt;
        e.run = v.e_run; e.halt = v.e_halt; e.done = v.e_done;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        checkOutput();
    endtask

    task automatic driveIdle();
        @(negedge i_clk);
        i_start = 0; i_halt = 0; i_step = 0; i_enable = 1;
        i_not_load = 0; i_redirect = 0;
    endtask

    initial begin
        // Vector table: tag, start, halt, step, en, nl, rd, rpc, npc, exp pc, exp cnt, run, halted, step_done
        addVec("idle_hold", 0,0,0,1,0,0, 0, 32'h200, RV, 0, 0,0,0);
        addVec("start",     1,0,0,1,0,0, 0, 32'h104, RV, 0, 1,0,0);
        for (int i = 1; i <= 10; i++)
            addVec("run", 0,0,0,1,0,0, 0, RV + 32'(4*i), RV + 32'(4*i), 16'(i), 1,0,0);
        for (int i = 0; i < 5; i++)
            addVec("disabled", 0,0,0,0,0,0, 0, 32'h500, 32'h128, 10, 1,0,0);
        addVec("halt",      0,1,0,1,0,0, 0, 32'h12C, 32'h128, 10, 0,1,0);
        addVec("halt_hold", 0,0,0,1,0,0, 0, 32'h600, 32'h128, 10, 0,1,0);
        addVec("halt_hold", 0,0,0,1,0,0, 0, 32'h604, 32'h128, 10, 0,1,0);
        addVec("resume",    1,0,0,1,0,0, 0, 32'h700, 32'h128, 10, 1,0,0);
        for (int k = 1; k <= 5; k++)
            addVec("resume_run", 0,0,0,1,0,0, 0, 32'h800 + 32'(4*k), 32'h800 + 32'(4*k), 16'(10+k), 1,0,0);
        for (int i = 0; i < 5; i++)
            addVec("stall", 0,0,0,1,1,0, 0, 32'h900, 32'h814, 15, 1,0,0);
        addVec("redirect",  0,0,0,1,1,1, 32'h400, 32'h900, 32'h400, 16, 1,0,0);
        addVec("post_redir",0,0,0,1,1,0, 0, 32'h900, 32'h400, 16, 1,0,0);
        addVec("start_halt",1,1,0,1,0,0, 0, 32'h904, 32'h400, 16, 0,1,0);
`ifdef PC_STEP_EN
        addVec("step_req",  0,0,1,1,0,0, 0, 32'h404, 32'h400, 16, 1,0,0);
        addVec("step_load", 0,0,0,1,0,0, 0, 32'h404, 32'h404, 17, 0,1,1);
        addVec("step_after",0,0,0,1,0,0, 0, 32'h504, 32'h404, 17, 0,1,0);
        addVec("sstep_req", 0,0,1,1,1,0, 0, 32'h408, 32'h404, 17, 1,0,0);
        addVec("sstep_wait",0,0,0,1,1,0, 0, 32'h408, 32'h404, 17, 1,0,0);
        addVec("sstep_wait",0,0,0,1,1,0, 0, 32'h408, 32'h404, 17, 1,0,0);
        addVec("sstep_load",0,0,0,1,0,0, 0, 32'h408, 32'h408, 18, 0,1,1);
        addVec("sstep_aft", 0,0,0,1,0,0, 0, 32'h508, 32'h408, 18, 0,1,0);
        addVec("hstep_req", 0,0,1,1,0,0, 0, 32'h40C, 32'h408, 18, 1,0,0);
        addVec("hstep_halt",0,1,0,1,0,0, 0, 32'h999, 32'h408, 18, 0,1,0);
`else
        addVec("step_ign",  0,0,1,1,0,0, 0, 32'h404, 32'h400, 16, 0,1,0);
        addVec("step_ign2", 0,0,0,1,0,0, 0, 32'h404, 32'h400, 16, 0,1,0);
`endif

        // Reset state, sampled while reset is still asserted and after release
        repeat (2) @(posedge i_clk);
        #1;
        checkValue("reset.pc", o_pc, RV);
        checkValue("reset.flags", {29'h0, o_running, o_halted, o_step_done}, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        checkValue("release.pc", o_pc, RV);
        checkValue("release.cnt", {16'h0, o_load_count}, 32'h0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Async reset mid-run: outputs must clear before the next clock edge
        driveIdle();
        i_start = 1;
        driveIdle();
        i_next_pc = 32'hABC0;
        @(negedge i_clk);
        checkValue("pre_reset.pc", o_pc, 32'hABC0);
        #1;
        i_reset = 1'b1;
        #1;
        checkValue("async_reset.pc", o_pc, RV);
        checkValue("async_reset.cnt", {16'h0, o_load_count}, 32'h0);
        checkValue("async_reset.run", {31'h0, o_running}, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Counter wrap: 65535 loads reach 16'hFFFF, two more wrap to 1
        driveIdle();
        i_start = 1;
        driveIdle();
        for (int i = 1; i <= 65535; i++) begin
            i_next_pc = 32'(i);
            @(negedge i_clk);
        end
        checkValue("wrap_pre.cnt", {16'h0, o_load_count}, 32'hFFFF);
        checkValue("wrap_pre.pc", o_pc, 32'd65535);
        i_next_pc = 32'hDEAD0000;
        @(negedge i_clk);
        checkValue("wrap_zero.cnt", {16'h0, o_load_count}, 32'h0);
        i_next_pc = 32'hDEAD0004;
        @(negedge i_clk);
        checkValue("wrap_one.cnt", {16'h0, o_load_count}, 32'h1);
        checkValue("wrap_one.pc", o_pc, 32'hDEAD0004);

        checkValue("scoreboard.drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
